// File: rtl/park_pkg.sv
// -----------------------------------------------------------------------------
// park_pkg
// Shared definitions for the parking entry stage.
//   SLOT_W / NUM_SLOTS : slot index width and slot count (NUM_SLOTS = 2**SLOT_W)
//   slot_t, occ_t, count_t : slot index, occupancy vector, slot count types
//   park_state_e       : entry FSM states (IDLE, ALLOC, ISSUE, GATE)
//   occ_popcount()     : number of occupied slots in an occupancy vector
// -----------------------------------------------------------------------------
package park_pkg;

   localparam int SLOT_W    = 3;
   localparam int NUM_SLOTS = 2 ** SLOT_W;

   typedef logic [SLOT_W-1:0]    slot_t;
   typedef logic [NUM_SLOTS-1:0] occ_t;
   typedef logic [SLOT_W:0]      count_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALLOC = 2'd1,
      ISSUE = 2'd2,
      GATE  = 2'd3
   } park_state_e;

   function automatic count_t occ_popcount(input occ_t occ);
      count_t cnt;
      cnt = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         cnt = cnt + count_t'(occ[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/park_free_finder.sv
// -----------------------------------------------------------------------------
// park_free_finder
// Combinational lowest-zero priority encoder over the occupancy vector.
//   occ      : occupancy, bit i = 1 means slot i is taken
//   idx      : lowest-numbered free slot (0 when none is free)
//   any_free : at least one slot is free
// -----------------------------------------------------------------------------
module park_free_finder
   import park_pkg::*;
(
   input  occ_t  occ,
   output slot_t idx,
   output logic  any_free
);

   // Scan from the top down so the lowest free index is the last one written.
   always_comb begin
      idx      = '0;
      any_free = ~(&occ);
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         idx = (!occ[i]) ? slot_t'(i) : idx;
      end
   end

endmodule

// File: rtl/park_token_issuer.sv
// -----------------------------------------------------------------------------
// park_token_issuer
// Entry-side stage of the parking system: tracks slot occupancy, allocates the
// lowest free slot to an arriving car, presents the token (slot ^ pattern) to
// the entry terminal, opens the barrier for GATE_CYCLES cycles, and releases
// slots reported by the exit path.
//
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   pattern      : encryption pattern, sampled in the ALLOC cycle only
//   entry_req    : car present at entry (level, sampled in IDLE)
//   token_valid  : token presented (registered)
//   token        : encrypted slot number (registered, stable while valid)
//   token_ack    : terminal accepted the token
//   entry_gate   : barrier open (registered)
//   full         : every slot occupied (from registered occupancy)
//   free_count   : number of free slots, 0..NUM_SLOTS
//   exit_valid   : one-cycle pulse, park_number is being vacated
//   park_number  : slot being vacated
//   exit_err     : one-cycle pulse, exit reported for an already free slot
//
// Optional build macro PARK_STATS_EN adds:
//   entries_total : saturating count of completed token handshakes
//   peak_occupied : highest occupied-slot count seen since reset
// -----------------------------------------------------------------------------
module park_token_issuer
   import park_pkg::*;
#(
   parameter int GATE_CYCLES = 4
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [SLOT_W-1:0] pattern,
   input  logic              entry_req,
   output logic              token_valid,
   output logic [SLOT_W-1:0] token,
   input  logic              token_ack,
   output logic              entry_gate,
   output logic              full,
   output logic [SLOT_W:0]   free_count,
   input  logic              exit_valid,
   input  logic [SLOT_W-1:0] park_number,
   output logic              exit_err
`ifdef PARK_STATS_EN
   ,
   output logic [7:0]        entries_total,
   output logic [SLOT_W:0]   peak_occupied
`endif
);

   localparam int GCNT_W = $clog2(GATE_CYCLES + 1);
   localparam logic [GCNT_W-1:0] GATE_LOAD = GCNT_W'(GATE_CYCLES);
   localparam logic [GCNT_W-1:0] GCNT_ONE  = GCNT_W'(1);

   park_state_e       state_q, state_d;
   occ_t              occ_q, occ_d;
   slot_t             token_q, token_d;
   logic              token_valid_q, token_valid_d;
   logic              entry_gate_q, entry_gate_d;
   logic              exit_err_q, exit_err_d;
   logic [GCNT_W-1:0] gate_cnt_q, gate_cnt_d;

   occ_t              set_mask;
   occ_t              clr_mask;
   slot_t             free_idx;
   logic              any_free;
   count_t            occupied_cnt;

   park_free_finder u_free_finder (
      .occ      (occ_q),
      .idx      (free_idx),
      .any_free (any_free)
   );

   // Occupancy-derived status; combinational from the registered vector.
   always_comb begin
      occupied_cnt = occ_popcount(occ_q);
      full         = &occ_q;
      free_count   = count_t'(NUM_SLOTS) - occupied_cnt;
   end

   // Next-state logic for the entry FSM and the independent exit path.
   always_comb begin
      state_d       = state_q;
      token_d       = token_q;
      token_valid_d = token_valid_q;
      entry_gate_d  = entry_gate_q;
      gate_cnt_d    = gate_cnt_q;
      exit_err_d    = 1'b0;
      set_mask      = '0;
      clr_mask      = '0;

      // Exit of a free slot only flags an error. ALLOC never picks a taken
      // slot, so an exit that collides with the allocation is always an
      // erroneous one: the set below wins and exit_err pulses.
      if (exit_valid) begin
         if (occ_q[park_number]) begin
            clr_mask[park_number] = 1'b1;
         end else begin
            exit_err_d = 1'b1;
         end
      end else begin
         exit_err_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (entry_req && !full) begin
               state_d = ALLOC;
            end else begin
               state_d = IDLE;
            end
         end
         ALLOC: begin
            // Allocation uses the registered occupancy, so a slot freed this
            // cycle becomes available to the next allocation.
            if (any_free) begin
               set_mask[free_idx] = 1'b1;
               token_d            = free_idx ^ pattern;
               token_valid_d      = 1'b1;
               state_d            = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (token_valid_q && token_ack) begin
               token_valid_d = 1'b0;
               entry_gate_d  = 1'b1;
               gate_cnt_d    = GATE_LOAD;
               state_d       = GATE;
            end else begin
               token_valid_d = 1'b1;
            end
         end
         GATE: begin
            if (gate_cnt_q == GCNT_ONE) begin
               entry_gate_d = 1'b0;
               gate_cnt_d   = '0;
               state_d      = IDLE;
            end else begin
               gate_cnt_d = gate_cnt_q - GCNT_ONE;
            end
         end
         default: begin
            state_d       = IDLE;
            token_valid_d = 1'b0;
            entry_gate_d  = 1'b0;
            gate_cnt_d    = '0;
         end
      endcase

      occ_d = (occ_q & ~clr_mask) | set_mask;
   end

   // State, occupancy and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         occ_q         <= '0;
         token_q       <= '0;
         token_valid_q <= 1'b0;
         entry_gate_q  <= 1'b0;
         exit_err_q    <= 1'b0;
         gate_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         occ_q         <= occ_d;
         token_q       <= token_d;
         token_valid_q <= token_valid_d;
         entry_gate_q  <= entry_gate_d;
         exit_err_q    <= exit_err_d;
         gate_cnt_q    <= gate_cnt_d;
      end
   end

   assign token_valid = token_valid_q;
   assign token       = token_q;
   assign entry_gate  = entry_gate_q;
   assign exit_err    = exit_err_q;

`ifdef PARK_STATS_EN
   logic [7:0] entries_total_q, entries_total_d;
   count_t     peak_occupied_q, peak_occupied_d;

   // Saturating handshake counter and occupancy high-water mark.
   always_comb begin
      entries_total_d = entries_total_q;
      peak_occupied_d = peak_occupied_q;
      if (token_valid_q && token_ack && (entries_total_q != 8'hFF)) begin
         entries_total_d = entries_total_q + 8'd1;
      end else begin
         entries_total_d = entries_total_q;
      end
      if (occupied_cnt > peak_occupied_q) begin
         peak_occupied_d = occupied_cnt;
      end else begin
         peak_occupied_d = peak_occupied_q;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entries_total_q <= 8'd0;
         peak_occupied_q <= '0;
      end else begin
         entries_total_q <= entries_total_d;
         peak_occupied_q <= peak_occupied_d;
      end
   end

   assign entries_total = entries_total_q;
   assign peak_occupied = peak_occupied_q;
`endif

endmodule

// File: tb/tb_park_token_issuer.sv
// -----------------------------------------------------------------------------
// tb_park_token_issuer
// Directed scenarios followed by a randomized entry/exit mix, checked against a
// slot-array reference model kept in the bench.
// -----------------------------------------------------------------------------
module tb_park_token_issuer;

   localparam int GATE_CYCLES = 4;
   localparam int NSLOT       = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] pattern = 3'd0;
   logic       entry_req = 1'b0;
   logic       token_valid;
   logic [2:0] token;
   logic       token_ack = 1'b0;
   logic       entry_gate;
   logic       full;
   logic [3:0] free_count;
   logic       exit_valid = 1'b0;
   logic [2:0] park_number = 3'd0;
   logic       exit_err;
`ifdef PARK_STATS_EN
   logic [7:0] entries_total;
   logic [3:0] peak_occupied;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: one flag per slot, plus statistics since last reset.
   bit model_occ [NSLOT];
   int model_handshakes = 0;
   int model_peak = 0;

   park_token_issuer #(.GATE_CYCLES(GATE_CYCLES)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pattern     (pattern),
      .entry_req   (entry_req),
      .token_valid (token_valid),
      .token       (token),
      .token_ack   (token_ack),
      .entry_gate  (entry_gate),
      .full        (full),
      .free_count  (free_count),
      .exit_valid  (exit_valid),
      .park_number (park_number),
      .exit_err    (exit_err)
`ifdef PARK_STATS_EN
      ,
      .entries_total (entries_total),
      .peak_occupied (peak_occupied)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int m_free();
      int c = 0;
      for (int i = 0; i < NSLOT; i++) if (!model_occ[i]) c++;
      return c;
   endfunction

   function automatic int m_lowest_free();
      for (int i = 0; i < NSLOT; i++) if (!model_occ[i]) return i;
      return -1;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < NSLOT; i++) model_occ[i] = 1'b0;
      model_handshakes = 0;
      model_peak = 0;
   endfunction

   function automatic void m_track_peak();
      if (NSLOT - m_free() > model_peak) model_peak = NSLOT - m_free();
   endfunction

   task automatic check_status(input string tag);
      check({tag, "_free_count"}, free_count, m_free());
      check({tag, "_full"}, full, (m_free() == 0));
   endtask

   // Full entry transaction; optional exit pulse (ex_slot >= 0) lands in the
   // allocation cycle. Expected slot is taken from the model before the exit.
   task automatic do_entry(input logic [2:0] pat, input int ex_slot, input int ack_delay);
      int         exp_slot;
      logic [2:0] exp_tok;
      logic       exp_err;
      int         gate_hi;
      exp_slot = m_lowest_free();
      exp_tok  = 3'(exp_slot) ^ pat;
      pattern   = pat;
      entry_req = 1'b1;
      step();
      entry_req = 1'b0;
      check("alloc_cycle_no_token", token_valid, 1'b0);
      exp_err = 1'b0;
      if (ex_slot >= 0) begin
         exit_valid  = 1'b1;
         park_number = 3'(ex_slot);
         exp_err     = !model_occ[ex_slot];
      end
      step();
      exit_valid = 1'b0;
      if (ex_slot >= 0 && model_occ[ex_slot]) model_occ[ex_slot] = 1'b0;
      model_occ[exp_slot] = 1'b1;
      m_track_peak();
      check("token_valid", token_valid, 1'b1);
      check("token", token, exp_tok);
      check("alloc_exit_err", exit_err, exp_err);
      check_status("alloc");
      for (int i = 0; i < ack_delay; i++) begin
         pattern = 3'($urandom);
         step();
         check("token_held_valid", token_valid, 1'b1);
         check("token_held_value", token, exp_tok);
      end
      token_ack = 1'b1;
      step();
      token_ack = 1'b0;
      model_handshakes++;
      check("token_dropped_after_ack", token_valid, 1'b0);
      gate_hi = 0;
      for (int i = 0; i < GATE_CYCLES + 4; i++) begin
         if (entry_gate === 1'b1) gate_hi++;
         step();
      end
      check("gate_cycles", gate_hi, GATE_CYCLES);
      check("gate_closed", entry_gate, 1'b0);
   endtask

   task automatic do_exit(input int slot);
      logic exp_err;
      exp_err     = !model_occ[slot];
      exit_valid  = 1'b1;
      park_number = 3'(slot);
      step();
      exit_valid = 1'b0;
      model_occ[slot] = 1'b0;
      check("exit_err", exit_err, exp_err);
      check_status("exit");
      step();
      check("exit_err_pulse_end", exit_err, 1'b0);
   endtask

   task automatic entry_while_full();
      entry_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("full_no_token", token_valid, 1'b0);
      end
      entry_req = 1'b0;
      step();
      check("full_still_no_token", token_valid, 1'b0);
      check_status("full_hold");
   endtask

   initial begin
      m_reset();
      // Reset state
      step();
      step();
      check("rst_token_valid", token_valid, 1'b0);
      check("rst_token", token, 3'd0);
      check("rst_entry_gate", entry_gate, 1'b0);
      check("rst_exit_err", exit_err, 1'b0);
      check_status("rst");
      rst_n = 1'b1;
      step();

      // First and second entries with pattern 010
      do_entry(3'b010, -1, 0);
      do_entry(3'b010, -1, 2);

      // Fill the lot, then a request while full is ignored
      for (int k = 0; k < 6; k++) do_entry(3'b010, -1, k % 3);
      check_status("filled");
      entry_while_full();

      // Free slot 3 while full; the next entry reuses it
      do_exit(3);
      do_entry(3'b010, -1, 1);

      // Erroneous exit of a free slot
      do_exit(5);
      do_exit(5);

      // Exit during ALLOC: allocation sees the old occupancy, freed slot next
      do_entry(3'b010, 0, 0);
      do_entry(3'b010, -1, 0);

      // Erroneous exit targeting the slot being allocated: set wins
      do_exit(2);
      do_entry(3'b110, 2, 1);

      // Asynchronous reset during ISSUE
      do_exit(1);
      do_exit(4);
      pattern   = 3'b010;
      entry_req = 1'b1;
      step();
      entry_req = 1'b0;
      step();
      check("pre_reset_token_valid", token_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      m_reset();
      check("async_rst_token_valid", token_valid, 1'b0);
      check("async_rst_token", token, 3'd0);
      check_status("async_rst");
      step();
      rst_n = 1'b1;
      step();
      do_entry(3'b010, -1, 0);

      // Randomized mix of entries and exits
      for (int it = 0; it < 80; it++) begin
         int r;
         r = $urandom_range(0, 3);
         if (r < 2) begin
            if (m_free() == 0) begin
               entry_while_full();
            end else begin
               int ex;
               ex = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
               do_entry(3'($urandom), ex, $urandom_range(0, 3));
            end
         end else begin
            do_exit($urandom_range(0, 7));
         end
      end

`ifdef PARK_STATS_EN
      step();
      check("stats_entries_total", entries_total, (model_handshakes > 255) ? 255 : model_handshakes);
      check("stats_peak_occupied", peak_occupied, model_peak);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
